sd_sector_io: RTL and testbench
===============================

SD_SECTOR_IO -- requirements
Module: sd_sector_io

Interface
REQ-001 Parameter TIMEOUT, default 24'd1000000: watchdog limit in clk cycles (used only when SD_SECTOR_IO_TIMEOUT_EN is defined).
REQ-002 clk  in  1  system clock; the single clock of the block.
REQ-003 reset_n  in  1  reset, asynchronous, active-low.
REQ-004 io_lba  in  32  sector address from the SD emulator; stable while io_rd or io_wr is high.
REQ-005 io_rd  in  1  sector read request, async to clk, level held until io_ack.
REQ-006 io_wr  in  1  sector write request, async to clk, level held until io_ack.
REQ-007 io_ack  out  1  request complete.
REQ-008 buf_addr  out  9  sector buffer byte address.
REQ-009 buf_wdata  out  8  byte written to the sector buffer.
REQ-010 buf_we  out  1  sector buffer write strobe.
REQ-011 buf_rdata  in  8  sector buffer read data, valid 1 clk after buf_addr.
REQ-012 host_cmd_valid  out  1  host command request.
REQ-013 host_cmd_wr  out  1  1 = write, 0 = read.
REQ-014 host_cmd_lba  out  32  latched io_lba.
REQ-015 host_cmd_ready  in  1  host accepts the command.
REQ-016 host_rx_data / host_rx_valid / host_rx_ready  in 8 / in 1 / out 1  read-data stream from host.
REQ-017 host_tx_data / host_tx_valid / host_tx_ready  out 8 / out 1 / in 1  write-data stream to host.
REQ-018 busy  out  1  high in every state except IDLE.
REQ-019 err  out  1  sticky timeout flag.

Function
REQ-020 The block SHALL pass io_rd and io_wr through 2-flop synchronizers and act on the synchronized rising edge only.
REQ-021 If both requests are seen high in the same cycle, the block SHALL serve the read.
REQ-022 States SHALL be IDLE, CMD, RD_DATA, WR_FETCH, WR_SEND, ACK.
REQ-023 IDLE->CMD on a request edge; the block SHALL latch host_cmd_lba=io_lba and host_cmd_wr, and clear buf_addr to 0.
REQ-024 CMD SHALL hold host_cmd_valid=1 until host_cmd_ready=1; that cycle it SHALL go to RD_DATA (read) or WR_FETCH (write).
REQ-025 RD_DATA SHALL drive host_rx_ready=1; on each rx handshake it SHALL pulse buf_we=1 with buf_wdata=host_rx_data at the current buf_addr, then increment buf_addr.
REQ-026 The handshake at buf_addr=511 SHALL end RD_DATA and go to ACK; buf_addr SHALL wrap to 0, never 512.
REQ-027 WR_FETCH SHALL last exactly 1 cycle; then WR_SEND SHALL register host_tx_data=buf_rdata and hold host_tx_valid=1 until host_tx_ready=1.
REQ-028 On a tx handshake with buf_addr<511, the block SHALL increment buf_addr and return to WR_FETCH; at buf_addr=511 it SHALL go to ACK.
REQ-029 ACK SHALL hold io_ack=1 until both synchronized requests are low, then return to IDLE with io_ack=0.
REQ-030 Request edges arriving while not in IDLE SHALL be ignored.
REQ-031 A full sector SHALL be exactly 512 buffer writes (read) or 512 tx beats (write).

Reset
REQ-032 reset_n low SHALL immediately force IDLE, all outputs to 0, and all synchronizers to 0, including mid-transfer.
REQ-033 After reset release, a request already held high SHALL be treated as a new edge.

Configuration
REQ-034 With SD_SECTOR_IO_TIMEOUT_EN defined, a counter SHALL count clk cycles in CMD, RD_DATA and WR_SEND, and clear on every handshake and on every state change.
REQ-035 When that counter reaches TIMEOUT, the block SHALL set err=1 and go to ACK; err SHALL stay set until reset.
REQ-036 Without SD_SECTOR_IO_TIMEOUT_EN, no counter SHALL be built, err SHALL be tied 0, and stalls SHALL wait indefinitely.

Verification
REQ-037 Read: io_lba=0x1234, pulse io_rd, host supplies bytes 0..255 twice -> host_cmd_lba=0x1234, host_cmd_wr=0; buffer[n]=n%256; io_ack high until io_rd low.
REQ-038 Write: buffer preloaded 0xFF-n, pulse io_wr, host_tx_ready toggles randomly -> 512 tx beats with data 0xFF-(n%256) in order, then io_ack.
REQ-039 io_rd and io_wr rise together -> read path taken, host_cmd_wr=0.
REQ-040 Assert reset_n=0 at byte 100 of a read -> busy=0, io_ack=0, buf_addr=0 immediately; with io_rd still high at release, the read restarts from byte 0.
REQ-041 With the macro defined and TIMEOUT=100, host_rx_valid held 0 -> err=1 and io_ack=1 after 100 cycles in RD_DATA; without the macro, busy stays 1 and err stays 0.

Source files
------------

// File: rtl/sd_sector_io_if.sv
// Host-side bundle of sd_sector_io: command request plus the read (rx) and
// write (tx) byte streams. The sector engine is the master, the host the slave.
interface sd_sector_io_if;
  logic        host_cmd_valid;
  logic        host_cmd_wr;
  logic [31:0] host_cmd_lba;
  logic        host_cmd_ready;
  logic [7:0]  host_rx_data;
  logic        host_rx_valid;
  logic        host_rx_ready;
  logic [7:0]  host_tx_data;
  logic        host_tx_valid;
  logic        host_tx_ready;

  modport master (
    output host_cmd_valid, host_cmd_wr, host_cmd_lba,
    input  host_cmd_ready,
    input  host_rx_data, host_rx_valid,
    output host_rx_ready,
    output host_tx_data, host_tx_valid,
    input  host_tx_ready
  );

  modport slave (
    input  host_cmd_valid, host_cmd_wr, host_cmd_lba,
    output host_cmd_ready,
    output host_rx_data, host_rx_valid,
    input  host_rx_ready,
    input  host_tx_data, host_tx_valid,
    output host_tx_ready
  );
endinterface

// File: rtl/sd_sector_io.sv
// Moves one 512-byte sector between the SD emulator's buffer and the host.
// Optional watchdog on host stalls is built when SD_SECTOR_IO_TIMEOUT_EN is defined.
module sd_sector_io #(
  parameter logic [23:0] TIMEOUT = 24'd1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] io_lba,
  input  logic        io_rd,
  input  logic        io_wr,
  output logic        io_ack,
  output logic [8:0]  buf_addr,
  output logic [7:0]  buf_wdata,
  output logic        buf_we,
  input  logic [7:0]  buf_rdata,
  sd_sector_io_if.master hif,
  output logic        busy,
  output logic        err
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD      = 3'd1;
  localparam logic [2:0] RD_DATA  = 3'd2;
  localparam logic [2:0] WR_FETCH = 3'd3;
  localparam logic [2:0] WR_SEND  = 3'd4;
  localparam logic [2:0] ACK      = 3'd5;

  logic [2:0]  state, state_nxt;
  logic [2:0]  rd_sync, wr_sync;   // [1:0] synchronizer, [2] previous level
  logic        rd_lvl, wr_lvl, rd_rise, wr_rise;
  logic [31:0] cmd_lba;
  logic        cmd_wr;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [8:0]  addr;
  logic        last_byte;
  logic        hs;
  logic        timed_out;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_sync <= 3'b000;
      wr_sync <= 3'b000;
    end else begin
      rd_sync <= {rd_sync[1:0], io_rd};
      wr_sync <= {wr_sync[1:0], io_wr};
    end
  end

  // The previous-level flop resets to 0, so a request held through reset
  // release is seen as a fresh edge.
  assign rd_lvl  = rd_sync[1];
  assign wr_lvl  = wr_sync[1];
  assign rd_rise = rd_sync[1] & ~rd_sync[2];
  assign wr_rise = wr_sync[1] & ~wr_sync[2];

  assign last_byte = (addr == 9'd511);

  assign hs = ((state == CMD)     && hif.host_cmd_ready) ||
              ((state == RD_DATA) && hif.host_rx_valid)  ||
              ((state == WR_SEND) && tx_valid && hif.host_tx_ready);

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (rd_rise || wr_rise) state_nxt = CMD;
      CMD:      if (hs) state_nxt = cmd_wr ? WR_FETCH : RD_DATA;
      RD_DATA:  if (hs && last_byte) state_nxt = ACK;
      WR_FETCH: state_nxt = WR_SEND;
      WR_SEND:  if (hs) state_nxt = last_byte ? ACK : WR_FETCH;
      ACK:      if (!rd_lvl && !wr_lvl) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (timed_out) state_nxt = ACK;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      addr     <= 9'd0;
      cmd_lba  <= 32'd0;
      cmd_wr   <= 1'b0;
      tx_data  <= 8'd0;
      tx_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (rd_rise || wr_rise) begin
          cmd_lba <= io_lba;
          cmd_wr  <= ~rd_rise;         // read wins when both rise together
          addr    <= 9'd0;
        end
        RD_DATA: if (hs) addr <= addr + 9'd1;   // 511 wraps to 0
        WR_SEND: begin
          // First WR_SEND cycle captures the buffer byte; valid rises after it.
          if (!tx_valid) begin
            tx_data  <= buf_rdata;
            tx_valid <= 1'b1;
          end else if (hif.host_tx_ready) begin
            tx_valid <= 1'b0;
            if (!last_byte) addr <= addr + 9'd1;
          end
        end
        default: ;
      endcase
      if (state_nxt != WR_SEND) tx_valid <= 1'b0;
    end
  end

`ifdef SD_SECTOR_IO_TIMEOUT_EN
  logic [23:0] tcnt;
  logic        counting;
  logic        err_q;

  assign counting  = (state == CMD) || (state == RD_DATA) || (state == WR_SEND);
  assign timed_out = counting && !hs && (tcnt == TIMEOUT - 24'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tcnt  <= 24'd0;
      err_q <= 1'b0;
    end else begin
      if (!counting || hs || (state_nxt != state)) tcnt <= 24'd0;
      else                                         tcnt <= tcnt + 24'd1;
      if (timed_out) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_timeout;

  // Without the watchdog, TIMEOUT is kept only for a uniform parameter list.
  assign unused_timeout = ^TIMEOUT;
  assign timed_out      = 1'b0;
  assign err            = 1'b0;
`endif

  assign io_ack    = (state == ACK);
  assign busy      = (state != IDLE);
  assign buf_addr  = addr;
  assign buf_we    = (state == RD_DATA) && hif.host_rx_valid;
  assign buf_wdata = buf_we ? hif.host_rx_data : 8'd0;

  assign hif.host_cmd_valid = (state == CMD);
  assign hif.host_cmd_wr    = cmd_wr;
  assign hif.host_cmd_lba   = cmd_lba;
  assign hif.host_rx_ready  = (state == RD_DATA);
  assign hif.host_tx_data   = tx_data;
  assign hif.host_tx_valid  = tx_valid;

endmodule

// File: tb/tb_sd_sector_io.sv
// Randomized bench for sd_sector_io: sector buffer and host modelled as arrays
// and queues; expected sector contents are computed from the transfer rules.
module tb_sd_sector_io;
  localparam logic [23:0] TMO = 24'd100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] io_lba = 32'd0;
  logic        io_rd = 1'b0;
  logic        io_wr = 1'b0;
  logic        io_ack;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_wdata;
  logic        buf_we;
  logic [7:0]  buf_rdata;
  logic        busy;
  logic        err;

  sd_sector_io_if hif();

  sd_sector_io #(.TIMEOUT(TMO)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .io_lba   (io_lba),
    .io_rd    (io_rd),
    .io_wr    (io_wr),
    .io_ack   (io_ack),
    .buf_addr (buf_addr),
    .buf_wdata(buf_wdata),
    .buf_we   (buf_we),
    .buf_rdata(buf_rdata),
    .hif      (hif.master),
    .busy     (busy),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Environment: sector buffer with one-cycle read latency, host with random backpressure.
  logic [7:0]  mem    [512];
  logic [7:0]  rx_pat [512];
  logic [7:0]  tx_got [$];
  logic [8:0]  addr_d;
  logic [31:0] cmd_lba;
  logic        cmd_wr;
  logic        rx_stall = 1'b1;
  int          rx_idx = 0;
  int          we_count = 0;
  int          cmd_count = 0;
  int          first_we_addr = -1;

  initial begin
    hif.host_cmd_ready = 1'b0;
    hif.host_rx_valid  = 1'b0;
    hif.host_rx_data   = 8'd0;
    hif.host_tx_ready  = 1'b0;
    buf_rdata = 8'd0;
    addr_d    = 9'd0;
    forever begin
      @(negedge clk);
      hif.host_cmd_ready = ($urandom_range(0, 2) == 0);
      hif.host_rx_valid  = !rx_stall && ($urandom_range(0, 3) != 0);
      hif.host_rx_data   = rx_pat[rx_idx[8:0]];
      hif.host_tx_ready  = 1'($urandom_range(0, 1));
      buf_rdata = mem[addr_d];
      addr_d    = buf_addr;
      #1;
      if (reset_n) begin
        if (hif.host_cmd_valid && hif.host_cmd_ready) begin
          cmd_count++;
          cmd_lba = hif.host_cmd_lba;
          cmd_wr  = hif.host_cmd_wr;
        end
        if (hif.host_rx_valid && hif.host_rx_ready) rx_idx++;
        if (buf_we) begin
          if (we_count == 0) first_we_addr = int'(buf_addr);
          mem[buf_addr] = buf_wdata;
          we_count++;
        end
        if (hif.host_tx_valid && hif.host_tx_ready) tx_got.push_back(hif.host_tx_data);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_counts();
    rx_idx = 0;
    we_count = 0;
    cmd_count = 0;
    first_we_addr = -1;
    cmd_lba = 32'hx;
    cmd_wr = 1'bx;
    tx_got.delete();
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (!io_ack && n < 6000) begin
      step();
      n++;
    end
    if (!io_ack) check({tag, "_ack_timeout"}, 32'(io_ack), 32'd1);
  endtask

  // Ack must persist while any request is high and drop once both are low.
  task automatic release_req(input string tag);
    int n = 0;
    repeat (5) step();
    check({tag, "_ack_hold"}, 32'(io_ack), 32'd1);
    io_rd = 1'b0;
    io_wr = 1'b0;
    while (io_ack && n < 8) begin
      step();
      n++;
    end
    check({tag, "_ack_drop"}, 32'(io_ack), 32'd0);
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic check_read(input string tag, input logic [31:0] lba);
    int bad = 0;
    check({tag, "_lba"}, cmd_lba, lba);
    check({tag, "_wr"}, 32'(cmd_wr), 32'd0);
    check({tag, "_we_count"}, 32'(we_count), 32'd512);
    check({tag, "_rx_beats"}, 32'(rx_idx), 32'd512);
    check({tag, "_first_addr"}, 32'(first_we_addr), 32'd0);
    check({tag, "_addr_wrap"}, 32'(buf_addr), 32'd0);
    for (int i = 0; i < 512; i++) if (mem[i] !== rx_pat[i]) bad++;
    check({tag, "_data_bad"}, 32'(bad), 32'd0);
  endtask

  task automatic start_read(input logic [31:0] lba, input bit counting_pat);
    for (int i = 0; i < 512; i++) begin
      rx_pat[i] = counting_pat ? 8'(i % 256) : 8'($urandom);
      mem[i] = 8'hxx;
    end
    clear_counts();
    rx_stall = 1'b0;
    io_lba = lba;
    io_rd = 1'b1;
  endtask

  task automatic do_read(input string tag, input logic [31:0] lba, input bit counting_pat);
    start_read(lba, counting_pat);
    wait_ack(tag);
    check_read(tag, lba);
    release_req(tag);
  endtask

  task automatic do_write(input string tag, input logic [31:0] lba, input bit down_pat);
    int bad = 0;
    logic [7:0] exp [512];
    for (int i = 0; i < 512; i++) begin
      exp[i] = down_pat ? 8'(8'hFF - (i % 256)) : 8'($urandom);
      mem[i] = exp[i];
    end
    clear_counts();
    rx_stall = 1'b1;
    io_lba = lba;
    io_wr = 1'b1;
    wait_ack(tag);
    check({tag, "_lba"}, cmd_lba, lba);
    check({tag, "_wr"}, 32'(cmd_wr), 32'd1);
    check({tag, "_tx_beats"}, 32'(tx_got.size()), 32'd512);
    check({tag, "_no_buf_we"}, 32'(we_count), 32'd0);
    for (int i = 0; i < 512; i++) if (i >= tx_got.size() || tx_got[i] !== exp[i]) bad++;
    check({tag, "_data_bad"}, 32'(bad), 32'd0);
    release_req(tag);
  endtask

  initial begin
    int n;
    int cyc;
    logic [31:0] lba;

    repeat (3) step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ack", 32'(io_ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(buf_addr), 32'd0);
    check("rst_outs", {28'd0, hif.host_cmd_valid, hif.host_rx_ready, hif.host_tx_valid, buf_we}, 32'd0);
    reset_n = 1'b1;
    repeat (3) step();

    do_read("rd_count", 32'h0000_1234, 1'b1);
    do_write("wr_down", 32'h0000_0042, 1'b1);

    for (int t = 0; t < 3; t++) begin
      lba = $urandom;
      if ($urandom_range(0, 1) == 1) do_read("rand_rd", lba, 1'b0);
      else                           do_write("rand_wr", lba, 1'b0);
      repeat ($urandom_range(1, 5)) step();
    end

    // Simultaneous requests: read served; ack holds until the write drops too.
    start_read(32'h00AB_CDEF, 1'b0);
    io_wr = 1'b1;
    wait_ack("both");
    check_read("both", 32'h00AB_CDEF);
    io_rd = 1'b0;
    repeat (6) step();
    check("both_ack_wr_held", 32'(io_ack), 32'd1);
    io_wr = 1'b0;
    repeat (6) step();
    check("both_ack_drop", 32'(io_ack), 32'd0);
    repeat (10) step();
    check("both_no_second_cmd", 32'(cmd_count), 32'd1);

    // A write edge during a read is ignored.
    start_read(32'h0000_0777, 1'b0);
    n = 0;
    while (rx_idx < 50 && n < 2000) begin step(); n++; end
    io_wr = 1'b1;
    wait_ack("ignore");
    check_read("ignore", 32'h0000_0777);
    release_req("ignore");
    repeat (10) step();
    check("ignore_cmd_count", 32'(cmd_count), 32'd1);
    check("ignore_stay_idle", 32'(busy), 32'd0);

    // Reset at byte 100 of a read; request held through release restarts it.
    start_read(32'h0000_5555, 1'b0);
    n = 0;
    while (rx_idx < 100 && n < 2000) begin step(); n++; end
    check("mid_reached", 32'(rx_idx >= 100), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ack", 32'(io_ack), 32'd0);
    check("mid_addr", 32'(buf_addr), 32'd0);
    check("mid_we", 32'(buf_we), 32'd0);
    repeat (3) step();
    for (int i = 0; i < 512; i++) mem[i] = 8'hxx;
    clear_counts();
    reset_n = 1'b1;
    wait_ack("mid_restart");
    check_read("mid_restart", 32'h0000_5555);
    check("mid_one_cmd", 32'(cmd_count), 32'd1);
    release_req("mid_restart");

    // Host never supplies read data.
    start_read(32'h0000_0099, 1'b0);
    rx_stall = 1'b1;
    n = 0;
    while (!hif.host_rx_ready && n < 200) begin step(); n++; end
    check("stall_entered", 32'(hif.host_rx_ready), 32'd1);
    cyc = 0;
`ifdef SD_SECTOR_IO_TIMEOUT_EN
    while (hif.host_rx_ready && cyc < 2000) begin step(); cyc++; end
    check("tmo_cycles", 32'(cyc), 32'(TMO));
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_ack", 32'(io_ack), 32'd1);
    release_req("tmo");
    check("tmo_err_sticky", 32'(err), 32'd1);
    reset_n = 1'b0;
    step();
    check("tmo_err_cleared", 32'(err), 32'd0);
`else
    while (hif.host_rx_ready && cyc < 300) begin step(); cyc++; end
    check("stall_cycles", 32'(cyc), 32'd300);
    check("stall_busy", 32'(busy), 32'd1);
    check("stall_err", 32'(err), 32'd0);
    check("stall_ack", 32'(io_ack), 32'd0);
    reset_n = 1'b0;
    step();
    check("stall_rst_busy", 32'(busy), 32'd0);
`endif
    io_rd = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (5) step();
    check("end_idle", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench time limit");
  end
endmodule
